// File: rtl/quad_gate_tester_if.sv
// rtl/quad_gate_tester_if.sv - pin bundle between the quad gate tester and the gate package
interface quad_gate_tester_if;
  logic       START;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Y;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] FAIL_MASK;
  logic [3:0] VEC_IDX;

  modport master (
    input  START, Y,
    output A, B, BUSY, DONE, PASS, FAIL_MASK, VEC_IDX
  );

  modport slave (
    output START, Y,
    input  A, B, BUSY, DONE, PASS, FAIL_MASK, VEC_IDX
  );
endinterface

// File: rtl/quad_gate_tester.sv
// rtl/quad_gate_tester.sv - walks four 2-input gates through their truth table and flags mismatches
module quad_gate_tester #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2
) (
  input logic                CLK,
  input logic                RST,
  quad_gate_tester_if.master bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] a_q, b_q, fail_q, vec_q, cnt_q;
  logic       busy_q, done_q, pass_q;
  logic [3:0] mism;
  logic [3:0] next_vec;
  logic [3:0] next_a, next_b;

  // Only the gate under test is driven; v0..v3 are (A,B) = (1,1),(0,1),(1,0),(0,0).
  function automatic logic [7:0] stim(input logic [3:0] idx);
    logic [3:0] a, b;
    a = '0;
    b = '0;
    a[idx[3:2]] = ~idx[0];
    b[idx[3:2]] = ~idx[1];
    return {a, b};
  endfunction

  assign next_vec         = vec_q + 4'd1;
  assign {next_a, next_b} = stim(next_vec);

  // Mismatch is the default; an unknown Y bit never matches and so stays flagged.
  always_comb begin
    mism = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (bus.Y[i] == TRUTH[{a_q[i], b_q[i]}]) mism[i] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= '0;
      vec_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            state  <= ST_RUN;
            a_q    <= 4'b0001;
            b_q    <= 4'b0001;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= '0;
            vec_q  <= '0;
            cnt_q  <= '0;
          end
        end
        ST_RUN: begin
          if (cnt_q == LAST_CNT) begin
            fail_q <= fail_q | mism;
            cnt_q  <= '0;
            if (vec_q == 4'hF) begin
              state  <= ST_DONE;
              a_q    <= '0;
              b_q    <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= ((fail_q | mism) == 4'h0);
            end else begin
              vec_q <= next_vec;
              a_q   <= next_a;
              b_q   <= next_b;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.FAIL_MASK = fail_q;
  assign bus.VEC_IDX   = vec_q;
endmodule
